// File: rtl/modulo_demux1_16_seq.sv
// Sequential 1-to-16 demultiplexer: routes a serial bit onto 16 registered channels,
// either one channel per load strobe or as an automatic 16-cycle scan with frame-done pulse.
module modulo_demux1_16_seq #(
    parameter bit CLEAR_ON_START = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    input  logic [3:0]  input_sel,
    input  logic        load,
    input  logic        scan_start,
    output logic [15:0] out,
    output logic [3:0]  sel_cur,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] out_q, out_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            StIdle: begin
                // scan_start wins over a simultaneous load; the load is dropped
                if (scan_start) begin
                    state_d = StScan;
                    cnt_d   = 4'd0;
                    if (CLEAR_ON_START) begin
                        out_d = 16'h0000;
                    end
                end else if (load) begin
                    out_d[input_sel] = data_in;
                end
            end
            StScan: begin
                out_d[cnt_q] = data_in;
                cnt_d        = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
        // Status flags are registered from the next state so they align with it
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            out_q        <= 16'h0000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out        = out_q;
    assign sel_cur    = cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_modulo_demux1_16_seq.sv
// Scoreboard bench: drives both CLEAR_ON_START variants with the same stimulus and
// compares every cycle against a frame-position reference model.
module tb_modulo_demux1_16_seq;

    logic        clk = 1'b0;
    logic        rst, data_in, load, scan_start;
    logic [3:0]  input_sel;
    logic [15:0] out0, out1;
    logic [3:0]  sel0, sel1;
    logic        busy0, busy1, fd0, fd1;

    always #5 clk = ~clk;

    modulo_demux1_16_seq #(.CLEAR_ON_START(1'b0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .input_sel(input_sel), .load(load),
        .scan_start(scan_start), .out(out0), .sel_cur(sel0), .busy(busy0), .frame_done(fd0)
    );

    modulo_demux1_16_seq #(.CLEAR_ON_START(1'b1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .input_sel(input_sel), .load(load),
        .scan_start(scan_start), .out(out1), .sel_cur(sel1), .busy(busy1), .frame_done(fd1)
    );

    typedef struct packed {
        logic [15:0] out0;
        logic [15:0] out1;
        logic [3:0]  sel;
        logic        busy;
        logic        fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pos = -1 idle, 0..15 next channel to capture, 16 frame done
    int          m_pos = -1;
    logic [15:0] m_out0 = 16'h0000;
    logic [15:0] m_out1 = 16'h0000;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic [3:0] s, input logic l,
                        input logic st);
        exp_t e;
        @(negedge clk);
        rst = r; data_in = d; input_sel = s; load = l; scan_start = st;
        if (r) begin
            m_pos = -1; m_out0 = 16'h0000; m_out1 = 16'h0000;
        end else if (m_pos < 0) begin
            if (st) begin
                m_pos  = 0;
                m_out1 = 16'h0000;
            end else if (l) begin
                m_out0[s] = d;
                m_out1[s] = d;
            end
        end else if (m_pos <= 15) begin
            m_out0[m_pos] = d;
            m_out1[m_pos] = d;
            m_pos++;
        end else begin
            m_pos = -1;
        end
        e.out0 = m_out0;
        e.out1 = m_out1;
        e.sel  = (m_pos >= 0 && m_pos <= 15) ? 4'(m_pos) : 4'd0;
        e.busy = (m_pos >= 0);
        e.fd   = (m_pos == 16);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 4'($urandom), 1'b0, 1'b0);
    endtask

    task automatic scan(input logic [15:0] pat, input logic junk);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b0, pat[i], 4'($urandom), junk & 1'($urandom), junk & 1'($urandom));
        step(1'b0, 1'($urandom), 4'($urandom), junk, junk);
    endtask

    // Monitor: DUT presents a result every cycle; pop and compare just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("out_c0", out0, e.out0);
                cmp("out_c1", out1, e.out1);
                cmp("sel_cur", {12'd0, sel0}, {12'd0, e.sel});
                cmp("sel_cur_c1", {12'd0, sel1}, {12'd0, e.sel});
                cmp("busy", {15'd0, busy0}, {15'd0, e.busy});
                cmp("busy_c1", {15'd0, busy1}, {15'd0, e.busy});
                cmp("frame_done", {15'd0, fd0}, {15'd0, e.fd});
                cmp("frame_done_c1", {15'd0, fd1}, {15'd0, e.fd});
            end
        end
    end

    initial begin
        logic r;
        rst = 1'b1; data_in = 1'b0; input_sel = 4'd0; load = 1'b0; scan_start = 1'b0;
        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        #1;
        cmp("reset_out", out0, 16'h0000);
        cmp("reset_busy", {15'd0, busy0}, 16'd0);
        // Single-shot writes
        step(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
        #1;
        cmp("single_8021", out0, 16'h8021);
        step(1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        #1;
        cmp("single_8001", out0, 16'h8001);
        // Preset all ones, then scan A5C3 with junk strobes in SCAN and DONE
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 1'b1, 1'b0);
        #1;
        cmp("preset_ffff", out0, 16'hFFFF);
        scan(16'hA5C3, 1'b1);
        #1;
        cmp("scan_a5c3", out0, 16'hA5C3);
        idle(2);
        // Simultaneous scan_start and load: scan wins, no write
        step(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
        #1;
        cmp("prio_nowrite", out0, 16'hA5C3);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(1);
        // Reset at scan cycle 7, then a clean frame
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'($urandom), 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        cmp("midreset_out", out0, 16'h0000);
        idle(1);
        scan(16'h1234, 1'b0);
        #1;
        cmp("scan_1234", out0, 16'h1234);
        idle(1);
        // Clear-on-start variant
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        cmp("clear_on_start", out1, 16'h0000);
        cmp("no_clear", out0, 16'hFFFF);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        cmp("zero_frame", out1, 16'h0000);
        idle(1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 40) == 0);
            step(r, 1'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        end
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
